// File: rtl/sram_responder_if.sv
// Control and status side of the external SRAM port.
// SRAM_DQ is not part of this bundle. It stays a plain inout wire on the
// responder so that the tristate bus resolves in one place.
interface sram_responder_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N;
    logic              rd_valid;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;
    logic              proto_err;

    // The controller side: drives the address and write strobe, observes status.
    modport master (
        output SRAM_ADDR, SRAM_WE_N,
        input  rd_valid, rd_count, wr_count, proto_err
    );

    // The responder side: emulates the SRAM chip.
    modport slave (
        input  SRAM_ADDR, SRAM_WE_N,
        output rd_valid, rd_count, wr_count, proto_err
    );
endinterface

// File: rtl/sram_responder.sv
// SRAM chip emulator. It has a fixed, parameterised read latency and a
// bidirectional data bus. Writes commit on the edge where WE_N is sampled low.
// A read returns data READ_LAT edges after its address is first sampled, and
// the data stays on the bus until the address changes or a write begins.
module sram_responder #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 17,
    parameter int unsigned DEPTH    = 65536,
    parameter int          READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [DATA_W-1:0]    SRAM_DQ,
    sram_responder_if.slave      bus
);
    localparam int       MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WR       = 2'd3
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_prev_addr;
    logic              r_prev_we_n;
    logic [3:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic [15:0]       r_rd_count;
    logic [15:0]       r_wr_count;
    logic              r_proto_err;

    logic              w_in_range;
    logic              w_addr_new;
    logic              w_rd_start;
    logic              w_wr_new;
    logic              w_rd_valid;
    logic [MEM_AW-1:0] w_idx;

    assign w_in_range = (32'(bus.SRAM_ADDR) < DEPTH);
    assign w_idx      = bus.SRAM_ADDR[MEM_AW-1:0];
    assign w_addr_new = (bus.SRAM_ADDR != r_prev_addr);
    // A read (re)starts on a fresh address, right after a write, or out of IDLE.
    assign w_rd_start = bus.SRAM_WE_N & (w_addr_new | ~r_prev_we_n | (r_state == IDLE));
    // A write is counted once per address, not once per low edge.
    assign w_wr_new   = ~bus.SRAM_WE_N & (r_prev_we_n | w_addr_new);

    // The WE_N term is deliberately combinational, so the bus is released
    // in the same cycle the controller starts driving write data.
    assign w_rd_valid = (r_state == RD_DRIVE) & bus.SRAM_WE_N;
    assign SRAM_DQ    = w_rd_valid ? r_rd_data : {DATA_W{1'bz}};

    assign bus.rd_valid  = w_rd_valid;
    assign bus.rd_count  = r_rd_count;
    assign bus.wr_count  = r_wr_count;
    assign bus.proto_err = r_proto_err;

    // Storage array: write port and read-data capture. No accesses are
    // taken while rst is held.
    // NOTE: the array and its read register have no reset. That keeps the
    // block mappable to RAM, and the contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!bus.SRAM_WE_N && w_in_range) begin
                r_mem[w_idx] <= SRAM_DQ;
            end
            if (w_rd_start) begin
                r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // Access FSM, latency counter, access counters and sticky error flag.
    // NOTE: all state uses non-blocking assignments. Every register then
    // sees the pre-edge values of the others, which the address and
    // write-strobe history comparisons depend on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev_addr <= '0;
            r_prev_we_n <= 1'b1;
            r_lat_cnt   <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_prev_addr <= bus.SRAM_ADDR;
            r_prev_we_n <= bus.SRAM_WE_N;

            if (!w_in_range) begin
                r_proto_err <= 1'b1;
            end

            if (!bus.SRAM_WE_N) begin
                r_state <= WR;
                if (w_wr_new) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end else if (w_rd_start) begin
                r_state   <= RD_WAIT;
                r_lat_cnt <= LAT_INIT;
            end else begin
                case (r_state)
                    RD_WAIT: begin
                        if (r_lat_cnt == 4'd0) begin
                            r_state    <= RD_DRIVE;
                            r_rd_count <= r_rd_count + 16'd1;
                        end else begin
                            r_lat_cnt <= r_lat_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with READ_LAT = 2 and DEPTH = 65536.
module tb_sram_responder;
    logic        clk;
    logic        rst;
    logic [31:0] tb_dq;
    logic        tb_drv;
    wire  [31:0] sram_dq;

    int n_vec  = 0;
    int n_miss = 0;

    sram_responder_if #(.ADDR_W(17)) bus ();

    assign sram_dq = tb_drv ? tb_dq : 32'bz;

    sram_responder #(
        .DATA_W  (32),
        .ADDR_W  (17),
        .DEPTH   (65536),
        .READ_LAT(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .SRAM_DQ(sram_dq),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one bus cycle, then settle just past the rising edge.
    task automatic step(input logic [16:0] a, input logic we_n, input logic [31:0] d, input logic drv);
        bus.SRAM_ADDR = a;
        bus.SRAM_WE_N = we_n;
        tb_dq         = d;
        tb_drv        = drv;
        @(posedge clk);
        #1;
    endtask

    // A full read: sampled at edge N, driving after edge N+2.
    task automatic read3(input logic [16:0] a);
        step(a, 1'b1, 32'h0, 1'b0);
        check("rd_wait_n", {31'b0, bus.rd_valid}, 32'd0);
        step(a, 1'b1, 32'h0, 1'b0);
        check("rd_wait_n1", {31'b0, bus.rd_valid}, 32'd0);
        step(a, 1'b1, 32'h0, 1'b0);
        check("rd_valid_n2", {31'b0, bus.rd_valid}, 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        tb_drv        = 1'b0;
        tb_dq         = '0;
        bus.SRAM_ADDR = '0;
        bus.SRAM_WE_N = 1'b1;

        // Reset: 5 ns .. 35 ns
        #5 rst = 1'b1;
        #15;
        check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rst_rd_count", {16'b0, bus.rd_count}, 32'd0);
        check("rst_wr_count", {16'b0, bus.wr_count}, 32'd0);
        check("rst_proto_err", {31'b0, bus.proto_err}, 32'd0);
        #15 rst = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_ADDR = 17'h00010;
        tb_dq         = 32'hDEADBEEF;
        tb_drv        = 1'b1;

        // Write then read
        step(17'h00010, 1'b0, 32'hDEADBEEF, 1'b1);
        check("wr1_count", {16'b0, bus.wr_count}, 32'd1);
        check("wr1_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        read3(17'h00010);
        check("rd1_data", sram_dq, 32'hDEADBEEF);
        check("rd1_count", {16'b0, bus.rd_count}, 32'd1);
        check("rd1_wr_count", {16'b0, bus.wr_count}, 32'd1);
        step(17'h00010, 1'b1, 32'h0, 1'b0);
        check("rd1_hold", sram_dq, 32'hDEADBEEF);
        check("rd1_hold_count", {16'b0, bus.rd_count}, 32'd1);

        // Preload 0x8, then abandon a read of 0x4 for 0x8
        step(17'h00008, 1'b0, 32'hCAFE0008, 1'b1);
        check("wr2_count", {16'b0, bus.wr_count}, 32'd2);
        step(17'h00004, 1'b1, 32'h0, 1'b0);
        check("rs_a4_valid", {31'b0, bus.rd_valid}, 32'd0);
        step(17'h00008, 1'b1, 32'h0, 1'b0);
        check("rs_chg_valid", {31'b0, bus.rd_valid}, 32'd0);
        step(17'h00008, 1'b1, 32'h0, 1'b0);
        check("rs_wait_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rs_no_count", {16'b0, bus.rd_count}, 32'd1);
        step(17'h00008, 1'b1, 32'h0, 1'b0);
        check("rs_valid", {31'b0, bus.rd_valid}, 32'd1);
        check("rs_data", sram_dq, 32'hCAFE0008);
        check("rs_count", {16'b0, bus.rd_count}, 32'd2);

        // Turnaround: the bus is released combinationally when WE_N falls
        bus.SRAM_WE_N = 1'b0;
        tb_dq         = 32'h12345678;
        tb_drv        = 1'b1;
        #1;
        check("ta_release", {31'b0, bus.rd_valid}, 32'd0);
        check("ta_bus", sram_dq, 32'h12345678);
        @(posedge clk);
        #1;
        check("ta_wr_count", {16'b0, bus.wr_count}, 32'd3);
        read3(17'h00008);
        check("ta_readback", sram_dq, 32'h12345678);
        check("ta_rd_count", {16'b0, bus.rd_count}, 32'd3);

        // Out of range: the write is dropped, the read returns 0, the flag sticks
        step(17'h00000, 1'b0, 32'h0000A5A5, 1'b1);
        check("oor_pre_err", {31'b0, bus.proto_err}, 32'd0);
        step(17'h10000, 1'b0, 32'hBAD0BAD0, 1'b1);
        check("oor_err", {31'b0, bus.proto_err}, 32'd1);
        check("oor_wr_count", {16'b0, bus.wr_count}, 32'd5);
        read3(17'h10000);
        check("oor_rd_zero", sram_dq, 32'h0);
        check("oor_rd_count", {16'b0, bus.rd_count}, 32'd4);
        read3(17'h00000);
        check("oor_alias", sram_dq, 32'h0000A5A5);
        check("oor_sticky", {31'b0, bus.proto_err}, 32'd1);

        // Back-to-back writes with WE_N held low
        step(17'h00020, 1'b0, 32'h0BB00020, 1'b1);
        step(17'h00021, 1'b0, 32'h0BB00021, 1'b1);
        step(17'h00022, 1'b0, 32'h0BB00022, 1'b1);
        step(17'h00023, 1'b0, 32'h0BB00023, 1'b1);
        check("b2b_wr_count", {16'b0, bus.wr_count}, 32'd9);
        read3(17'h00020);
        check("b2b_rd0", sram_dq, 32'h0BB00020);
        read3(17'h00021);
        check("b2b_rd1", sram_dq, 32'h0BB00021);
        read3(17'h00022);
        check("b2b_rd2", sram_dq, 32'h0BB00022);
        read3(17'h00023);
        check("b2b_rd3", sram_dq, 32'h0BB00023);
        check("b2b_rd_count", {16'b0, bus.rd_count}, 32'd9);

        // Asynchronous reset in the middle of a driven read
        #4 rst = 1'b1;
        #1;
        check("arst_release", {31'b0, bus.rd_valid}, 32'd0);
        check("arst_rd_count", {16'b0, bus.rd_count}, 32'd0);
        check("arst_wr_count", {16'b0, bus.wr_count}, 32'd0);
        check("arst_err", {31'b0, bus.proto_err}, 32'd0);
        @(posedge clk);
        #5 rst = 1'b0;
        read3(17'h00021);
        check("arst_mem_kept", sram_dq, 32'h0BB00021);
        check("arst_rd_count1", {16'b0, bus.rd_count}, 32'd1);

        // Counter wrap: 65537 writes, each to a new address
        for (int i = 0; i < 65537; i++) begin
            step(17'(i % 65536), 1'b0, 32'(i), 1'b1);
        end
        check("wrap_wr_count", {16'b0, bus.wr_count}, 32'd1);
        read3(17'h00000);
        check("wrap_rd_last", sram_dq, 32'd65536);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
